// File: rtl/uartlite_pkg.sv
// Shared constants and FSM state types for the AXI-Lite UART responder.
package uartlite_pkg;

  // Register indices decoded from addr[3:2].
  localparam logic [1:0] ADDR_RX   = 2'd0;
  localparam logic [1:0] ADDR_TX   = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int unsigned STAT_RX_VALID = 0;
  localparam int unsigned STAT_RX_FULL  = 1;
  localparam int unsigned STAT_TX_EMPTY = 2;
  localparam int unsigned STAT_TX_FULL  = 3;
  localparam int unsigned STAT_INTR_EN  = 4;
  localparam int unsigned STAT_OVERRUN  = 5;

  localparam int unsigned CTRL_FLUSH_TX = 0;
  localparam int unsigned CTRL_FLUSH_RX = 1;
  localparam int unsigned CTRL_INTR_EN  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; flush has priority over push and pop.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uartlite_axi_responder.sv
// AXI-Lite register front end for a UART: RX/TX byte FIFOs, status, control and interrupt.
module uartlite_axi_responder
  import uartlite_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  input  logic        tx_byte_ready,
  output logic        intr
);

  w_state_e    w_state_q;
  r_state_e    r_state_q;
  logic        aw_hs, ar_hs;
  logic [1:0]  wr_addr, rd_addr;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]  rx_head;
  logic        flush_tx_q, flush_rx_q, intr_en_q, overrun_q;
  logic        rx_empty_q, tx_empty_q;
  logic [31:0] stat, rdata_d;
  logic        unused;

  assign unused  = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb, s_axi_wdata[31:8]};
  assign wr_addr = s_axi_awaddr[3:2];
  assign rd_addr = s_axi_araddr[3:2];

  // AW and W are accepted together, only when both are presented.
  assign aw_hs         = (w_state_q == WIdle) && s_axi_awvalid && s_axi_wvalid;
  assign s_axi_awready = aw_hs;
  assign s_axi_wready  = aw_hs;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign s_axi_rresp   = RESP_OKAY;
  assign tx_byte_valid = !tx_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (m_axi_aclk),
    .rst_n     (m_axi_aresetn),
    .push      (rx_byte_valid),
    .push_data (rx_byte),
    .pop       (ar_hs && (rd_addr == ADDR_RX)),
    .flush     (flush_rx_q),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (m_axi_aclk),
    .rst_n     (m_axi_aresetn),
    .push      (aw_hs && (wr_addr == ADDR_TX)),
    .push_data (s_axi_wdata[7:0]),
    .pop       (tx_byte_ready),
    .flush     (flush_tx_q),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_byte)
  );

  always_comb begin
    stat                = '0;
    stat[STAT_RX_VALID] = !rx_empty;
    stat[STAT_RX_FULL]  = rx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_TX_FULL]  = tx_full;
    stat[STAT_INTR_EN]  = intr_en_q;
    stat[STAT_OVERRUN]  = overrun_q;
  end

  always_comb begin
    rdata_d = '0;
    case (rd_addr)
      ADDR_RX:   if (!rx_empty) rdata_d = {24'd0, rx_head};
      ADDR_STAT: rdata_d = stat;
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      w_state_q    <= WIdle;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      intr_en_q    <= 1'b0;
      flush_tx_q   <= 1'b0;
      flush_rx_q   <= 1'b0;
    end else begin
      flush_tx_q <= 1'b0;
      flush_rx_q <= 1'b0;
      case (w_state_q)
        WIdle: begin
          if (aw_hs) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= (wr_addr == ADDR_TX && tx_full) ? RESP_SLVERR : RESP_OKAY;
            if (wr_addr == ADDR_CTRL) begin
              flush_tx_q <= s_axi_wdata[CTRL_FLUSH_TX];
              flush_rx_q <= s_axi_wdata[CTRL_FLUSH_RX];
              intr_en_q  <= s_axi_wdata[CTRL_INTR_EN];
            end
            w_state_q <= WResp;
          end
        end
        default: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            w_state_q    <= WIdle;
          end
        end
      endcase
    end
  end

  // arready is held low through reset and rises on the first clock after release.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state_q     <= RIdle;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      case (r_state_q)
        RIdle: begin
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rdata_d;
            r_state_q     <= RData;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        default: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state_q     <= RIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      overrun_q  <= 1'b0;
      rx_empty_q <= 1'b1;
      tx_empty_q <= 1'b1;
      intr       <= 1'b0;
    end else begin
      if (rx_byte_valid && rx_full) overrun_q <= 1'b1;
      else if (ar_hs && rd_addr == ADDR_STAT) overrun_q <= 1'b0;
      rx_empty_q <= rx_empty;
      tx_empty_q <= tx_empty;
      intr       <= intr_en_q && ((rx_empty_q && !rx_empty) || (!tx_empty_q && tx_empty));
    end
  end

endmodule

// File: doc/uartlite_axi_responder.md
UARTLITE_AXI_RESPONDER -- requirements
Module: uartlite_axi_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, entries per byte FIFO; power of two, 4..64.
REQ-002 Reset m_axi_aresetn, asynchronous, active-low; clock m_axi_aclk.
REQ-003 m_axi_aclk  in  1  clock.
REQ-004 m_axi_aresetn  in  1  asynchronous active-low reset.
REQ-005 s_axi_awaddr/awvalid/awready  in/in/out  4/1/1  write address channel.
REQ-006 s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel; wstrb ignored.
REQ-007 s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-008 s_axi_araddr/arvalid/arready  in/in/out  4/1/1  read address channel.
REQ-009 s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-010 rx_byte/rx_byte_valid  in/in  8/1  byte from serial deserializer; one-cycle strobe.
REQ-011 tx_byte/tx_byte_valid/tx_byte_ready  out/out/in  8/1/1  byte to serializer; valid/ready handshake.
REQ-012 intr  out  1  one-cycle interrupt pulse.

Function
REQ-013 Register map: 0x0 RX FIFO (read pops), 0x4 TX FIFO (write pushes), 0x8 STAT (read), 0xC CTRL (write); only addr[3:2] decoded.
REQ-014 STAT bits: [0] rx_valid, [1] rx_full, [2] tx_empty, [3] tx_full, [4] intr_en, [5] overrun; [31:6] zero.
REQ-015 CTRL write: bit0 flushes TX FIFO, bit1 flushes RX FIFO, bit4 written into intr_en; flush takes effect next cycle.
REQ-016 Write FSM W_IDLE -> W_RESP: awready=wready=1 only in W_IDLE when awvalid&&wvalid, same cycle; bvalid asserted next cycle, held until bready, then W_IDLE.
REQ-017 Write to 0x4 with TX not full pushes wdata[7:0], bresp OKAY(00); TX full drops byte, bresp SLVERR(10).
REQ-018 Writes to 0x0/0x8 ignored, bresp OKAY.
REQ-019 Read FSM R_IDLE -> R_DATA: arready=1 in R_IDLE; on handshake rdata registered, rvalid next cycle, held stable until rready, then R_IDLE.
REQ-020 Read 0x0 with RX non-empty returns {24'd0, head byte} and pops at handshake; RX empty returns 0, rresp OKAY, no pop.
REQ-021 Read 0x4/0xC returns 0, OKAY; read 0x8 returns STAT and clears overrun at handshake.
REQ-022 Read and write channels independent; simultaneous AW/W and AR handshakes both accepted same cycle.
REQ-023 rx_byte_valid with RX full drops byte, sets overrun; push and pop same cycle on non-full, non-empty FIFO leaves count unchanged.
REQ-024 Simultaneous push and flush: flush wins, FIFO empty after.
REQ-025 tx_byte = TX head, tx_byte_valid = !tx_empty; pop when tx_byte_valid&&tx_byte_ready.
REQ-026 intr pulses one cycle, intr_en=1, on RX empty->non-empty or TX non-empty->empty transitions; none while intr_en=0.
REQ-027 FIFO pointers width log2(FIFO_DEPTH)+1, wrap modulo 2*FIFO_DEPTH; full when MSBs differ and lower bits equal.

Reset
REQ-028 On reset: awready, wready, arready, bvalid, rvalid, tx_byte_valid, intr = 0 (arready rises first cycle after release); bresp, rresp, rdata = 0; FIFOs empty; intr_en, overrun = 0; FSMs idle.
REQ-029 Reset mid-transaction abandons it; no response issued after release.

Structure
REQ-030 Package uartlite_pkg holds register addresses, STAT bit indices, CTRL bit indices, RESP_OKAY/RESP_SLVERR constants.
REQ-031 Sub-module byte_fifo (parameter DEPTH; push, pop, flush, full, empty, head) instantiated twice.

Verification
REQ-032 rx_byte 0x41, 0x42 strobed; read 0x8 -> 0x05; read 0x0 twice -> 0x41, 0x42; read 0x8 -> 0x04.
REQ-033 17 rx bytes into empty RX (depth 16) -> STAT 0x07 with overrun 0x27; second STAT read -> 0x07.
REQ-034 tx_byte_ready=0, 17 writes to 0x4 -> 16 OKAY, 17th SLVERR, STAT bit3=1; ready=1 -> 16 bytes out in order.
REQ-035 CTRL 0x10 written, then rx_byte 0x58 -> intr one-cycle pulse; CTRL 0x00 repeat -> no pulse.
REQ-036 AW and W issued two cycles apart, bready held low 3 cycles -> no ready until both valid, bvalid held stable.
REQ-037 aresetn dropped while rvalid=1 with RX holding 3 bytes -> rvalid=0, STAT after release reads 0x04.
